seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_scan_display.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared segment encoding for the multiplexed seven-segment scanner.
package seg_pkg;

  localparam int unsigned SEG_W   = 8;
  localparam int unsigned HEX_W   = 4;
  localparam int unsigned PHASES  = 16;
  localparam int unsigned PHASE_W = $clog2(PHASES);

  // Segment bit order: bit7 = a down to bit0 = dp, all active-low
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic dp;
  } seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  localparam seg_t SEG_0 = 8'b0000_0011;
  localparam seg_t SEG_1 = 8'b1001_1111;
  localparam seg_t SEG_2 = 8'b0010_0101;
  localparam seg_t SEG_3 = 8'b0000_1101;
  localparam seg_t SEG_4 = 8'b1001_1001;
  localparam seg_t SEG_5 = 8'b0100_1001;
  localparam seg_t SEG_6 = 8'b0100_0001;
  localparam seg_t SEG_7 = 8'b0001_1111;
  localparam seg_t SEG_8 = 8'b0000_0001;
  localparam seg_t SEG_9 = 8'b0000_1001;
  localparam seg_t SEG_A = 8'b0000_0101;
  localparam seg_t SEG_B = 8'b1100_0001;
  localparam seg_t SEG_C = 8'b0110_0011;
  localparam seg_t SEG_D = 8'b1000_0101;
  localparam seg_t SEG_E = 8'b0110_0001;
  localparam seg_t SEG_F = 8'b0111_0001;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (dp left off).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [HEX_W-1:0] hex,
  output seg_t             seg_c
);

  // Full 16-entry lookup
  always_comb begin
    seg_c = SEG_OFF;
    case (hex)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with frame-shadowed digits and PWM dimming.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned N_DIG = 6,
  parameter int unsigned DIV   = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] num,
  input  logic [N_DIG-1:0]   dp,
  input  logic [N_DIG-1:0]   blank,
  input  logic               lzb,
  input  logic [3:0]         bright,
  input  logic               en,
  output logic [SEG_W-1:0]   seg_leds,
  output logic [N_DIG-1:0]   seg_ncs,
  output logic               frame_start
);

  // The DIV-cycle prescaler is kept as a (sub, phase) pair so PWM phase needs no divider
  localparam int unsigned SUB_DIV = DIV / PHASES;
  localparam int unsigned SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(PHASES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_DIG - 1);

  logic [SUB_W-1:0]   sub_q, sub_nxt;
  logic [PHASE_W-1:0] phase_q, phase_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic               init_q;
  logic               wrap;

  logic [4*N_DIG-1:0] num_q, num_nxt;
  logic [N_DIG-1:0]   dp_q, dp_nxt;
  logic [N_DIG-1:0]   blank_q, blank_nxt;
  logic               lzb_q, lzb_nxt;

  logic [HEX_W-1:0]   digit;
  logic               dp_bit;
  logic               dark;
  logic               zero_above;
  logic [N_DIG-1:0]   lz_mask;
  logic               lit;
  seg_t               pat;
  seg_t               leds_nxt;
  logic [N_DIG-1:0]   ncs_nxt;

  // Prescaler, phase and digit index; the first cycle after reset behaves as a frame wrap
  always_comb begin
    sub_nxt   = sub_q + SUB_W'(1);
    phase_nxt = phase_q;
    idx_nxt   = idx_q;
    wrap      = 1'b0;
    if (init_q) begin
      sub_nxt   = '0;
      phase_nxt = '0;
      idx_nxt   = '0;
      wrap      = 1'b1;
    end else if (sub_q == SUB_LAST) begin
      sub_nxt   = '0;
      phase_nxt = phase_q + PHASE_W'(1);
      if (phase_q == PH_LAST) begin
        if (idx_q == IDX_LAST) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Shadow copy of the frame-stable inputs, refreshed only on a frame wrap
  always_comb begin
    num_nxt   = wrap ? num   : num_q;
    dp_nxt    = wrap ? dp    : dp_q;
    blank_nxt = wrap ? blank : blank_q;
    lzb_nxt   = wrap ? lzb   : lzb_q;
  end

  // Leading-zero mask and selection of the digit that owns the upcoming slot
  always_comb begin
    digit      = '0;
    dp_bit     = 1'b0;
    dark       = 1'b0;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      zero_above = zero_above & (num_nxt[4*i +: HEX_W] == 4'h0);
      lz_mask[i] = lzb_nxt & zero_above;
    end
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        digit  = num_nxt[4*i +: HEX_W];
        dp_bit = dp_nxt[i];
        dark   = blank_nxt[i] | lz_mask[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .hex   (digit),
    .seg_c (pat)
  );

  // Next segment/select drive: lit only when enabled, not blanked and inside the duty window
  always_comb begin
    lit      = en & ~dark & (phase_nxt <= bright);
    leds_nxt = SEG_OFF;
    ncs_nxt  = '1;
    if (lit) begin
      leds_nxt    = pat;
      leds_nxt.dp = pat.dp & ~dp_bit;
      for (int i = 0; i < N_DIG; i++) begin
        ncs_nxt[i] = (idx_nxt != IDX_W'(i));
      end
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      init_q      <= 1'b1;
      num_q       <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      lzb_q       <= 1'b0;
      seg_leds    <= SEG_OFF;
      seg_ncs     <= '1;
      frame_start <= 1'b0;
    end else begin
      sub_q       <= sub_nxt;
      phase_q     <= phase_nxt;
      idx_q       <= idx_nxt;
      init_q      <= 1'b0;
      num_q       <= num_nxt;
      dp_q        <= dp_nxt;
      blank_q     <= blank_nxt;
      lzb_q       <= lzb_nxt;
      seg_leds    <= leds_nxt;
      seg_ncs     <= ncs_nxt;
      frame_start <= wrap;
    end
  end

endmodule
